// File: rtl/i2s_tx.sv
// I2S master transmitter: derives BCK/LRCK from an 8-bit prescaler and serialises
// stereo samples MSB-first from a one-deep holding register into the DAC.
module i2s_tx #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    mute,
    input  logic signed [WIDTH-1:0] left_in,
    input  logic signed [WIDTH-1:0] right_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    sample_req,
    output logic                    scki,
    output logic                    bck,
    output logic                    lrck,
    output logic                    dout,
    output logic                    underrun,
    output logic [CNT_W-1:0]        underrun_cnt
);

    logic [7:0]              p;
    logic [7:0]              p_next;
    logic [4:0]              slot_next;
    logic                    chan_next;
    logic                    bit_next;
    logic                    fl;
    logic                    accept;
    logic                    hold_full;
    logic signed [WIDTH-1:0] hold_l;
    logic signed [WIDTH-1:0] hold_r;
    logic signed [WIDTH-1:0] active_l;
    logic signed [WIDTH-1:0] active_r;

    // Slot 0 carries the I2S one-bit delay; slots 1..WIDTH carry MSB..LSB; the rest are zero.
    function automatic logic slot_bit(input logic [WIDTH-1:0] word, input logic [4:0] slot);
        logic b;
        b = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (slot == 5'(WIDTH - i)) b = word[i];
        end
        return b;
    endfunction

    assign p_next    = p + 8'd1;
    assign slot_next = p_next[6:2];
    assign chan_next = p_next[7];
    assign bit_next  = slot_bit(chan_next ? active_r : active_l, slot_next);

    assign fl           = ~reset & en & (p == 8'hFF);
    assign sample_ready = ~reset & ~hold_full;
    assign accept       = sample_valid & sample_ready;
    assign sample_req   = fl;
    assign scki         = clk;
    assign bck          = p[1];
    assign lrck         = p[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            p <= 8'd0;
        end else if (en) begin
            p <= p_next;
        end else begin
            p <= 8'd0;
        end
    end

    // dout changes only as p wraps to a new slot (bck falling), so it is stable at bck rising.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            dout <= 1'b0;
        end else if (p[1:0] == 2'b11) begin
            dout <= bit_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_l <= left_in;
            hold_r <= right_in;
        end
    end

    // A handshake coinciding with an empty-hold frame load lands in hold, not active.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
        end else if (fl) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_l <= '0;
            active_r <= '0;
        end else if (fl) begin
            if (hold_full && !mute) begin
                active_l <= hold_l;
                active_r <= hold_r;
            end else begin
                active_l <= '0;
                active_r <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (fl && !hold_full) begin
            underrun <= 1'b1;
            if (underrun_cnt != {CNT_W{1'b1}}) begin
                underrun_cnt <= underrun_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: spec-level model produces expected serial frames into a queue,
// a monitor pops one bit per BCK rising edge and checks control outputs every cycle.
module tb_i2s_tx;
    localparam int WIDTH = 24;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b1;
    logic mute = 1'b0;
    logic sample_valid = 1'b0;
    logic signed [WIDTH-1:0] left_in = '0;
    logic signed [WIDTH-1:0] right_in = '0;

    logic sample_ready, sample_req, scki, bck, lrck, dout, underrun;
    logic [CNT_W-1:0] underrun_cnt;
    logic sample_ready2, sample_req2, scki2, bck2, lrck2, dout2, underrun2;
    logic [1:0] underrun_cnt2;

    always #5 clk = ~clk;

    i2s_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .mute(mute),
        .left_in(left_in), .right_in(right_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_req(sample_req), .scki(scki),
        .bck(bck), .lrck(lrck), .dout(dout), .underrun(underrun),
        .underrun_cnt(underrun_cnt)
    );

    i2s_tx #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .mute(mute),
        .left_in(left_in), .right_in(right_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready2), .sample_req(sample_req2), .scki(scki2),
        .bck(bck2), .lrck(lrck2), .dout(dout2), .underrun(underrun2),
        .underrun_cnt(underrun_cnt2)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cycle = 0;

    // Reference model state
    int m_p = 0;
    bit m_full = 0;
    bit m_underrun = 0;
    int m_cnt = 0;
    logic [WIDTH-1:0] m_hold_l = '0, m_hold_r = '0;
    logic [WIDTH-1:0] m_act_l = '0, m_act_r = '0;
    bit exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cycle);
    endtask

    // One 64-bit-clock frame: left half then right half, 32 slots each.
    function automatic void push_frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        for (int ch = 0; ch < 2; ch++) begin
            for (int s = 0; s < 32; s++) begin
                bit b;
                b = 1'b0;
                if (s >= 1 && s <= WIDTH) b = (ch == 1) ? r[WIDTH-s] : l[WIDTH-s];
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic model_step();
        bit acc, fl;
        acc = sample_valid && !reset && !m_full;
        fl  = !reset && en && (m_p == 255);
        if (reset) begin
            m_p = 0; m_full = 0; m_underrun = 0; m_cnt = 0;
            m_act_l = '0; m_act_r = '0;
            exp_q.delete();
            push_frame('0, '0);
        end else begin
            if (fl) begin
                if (m_full) begin
                    m_act_l = mute ? '0 : m_hold_l;
                    m_act_r = mute ? '0 : m_hold_r;
                    m_full = 0;
                end else begin
                    m_act_l = '0; m_act_r = '0;
                    m_underrun = 1;
                    m_cnt++;
                end
                push_frame(m_act_l, m_act_r);
            end
            if (acc) begin
                m_hold_l = left_in; m_hold_r = right_in; m_full = 1;
            end
            if (en) begin
                m_p = (m_p + 1) % 256;
            end else begin
                // Restart after enable replays a whole frame of the retained active pair.
                m_p = 0;
                exp_q.delete();
                push_frame(m_act_l, m_act_r);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
            model_step();
        end
    end

    initial begin
        bit prev_bck;
        bit e;
        prev_bck = 0;
        forever begin
            @(posedge clk);
            #1;
            chk("bck", bck, (m_p >> 1) & 1);
            chk("lrck", lrck, (m_p >> 7) & 1);
            chk("bck2", bck2, (m_p >> 1) & 1);
            chk("sample_ready", sample_ready, int'(!reset && !m_full));
            chk("sample_req", sample_req, int'(!reset && en && m_p == 255));
            chk("sample_req2", sample_req2, int'(!reset && en && m_p == 255));
            chk("underrun", underrun, m_underrun);
            chk("underrun2", underrun2, m_underrun);
            chk("underrun_cnt", underrun_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
            chk("underrun_cnt_sat", underrun_cnt2, (m_cnt > 3) ? 3 : m_cnt);
            if (reset || !en) chk("dout_parked", dout, 0);
            if (bck && !prev_bck) begin
                if (exp_q.size() == 0) begin
                    chk("dout_unexpected_bit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", dout, e);
                    chk("dout2", dout2, e);
                end
            end
            prev_bck = bck;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_p(input int target);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (m_p != target && k < 600);
        if (m_p != target) timeout("wait_p");
    endtask

    task automatic send(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        int k;
        left_in = l;
        right_in = r;
        sample_valid = 1'b1;
        k = 0;
        while (!sample_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k == 2000) timeout("send_handshake");
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        wait_cycles(3);
        reset = 1'b0;

        wait_cycles(10);
        send(24'hA5A5A5, 24'h5A5A5A);
        wait_cycles(600);

        // Starvation: several underrun frames in a row
        wait_cycles(800);

        send(24'h111111, 24'h111111);
        send(24'h222222, 24'h222222);
        wait_cycles(800);

        wait_p(200);
        send(24'h7FFFFF, 24'h7FFFFF);
        wait_p(250);
        mute = 1'b1;
        wait_p(10);
        mute = 1'b0;
        send(24'h123456, 24'h654321);
        wait_cycles(600);

        // Handshake landing in the frame-load cycle with hold empty
        wait_p(255);
        send(24'h0F0F0F, 24'hF0F0F0);
        wait_cycles(600);

        wait_p(20);
        send(24'h345678, 24'h876543);
        wait_p(60);
        en = 1'b0;
        wait_cycles(20);
        en = 1'b1;
        wait_cycles(600);

        for (int i = 0; i < 16; i++) begin
            wait_cycles($urandom_range(0, 300));
            mute = ($urandom_range(0, 5) == 0);
            send(WIDTH'($urandom), WIDTH'($urandom));
        end
        mute = 1'b0;
        wait_cycles(600);

        wait_cycles(256 * 5 + 10);

        wait_p(40);
        send(24'h800001, 24'h7FFFFE);
        wait_p(100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S master transmitter driving a stereo DAC (e.g. PCM5102-class) from the 12 MHz system clock. Generates BCK = clk/4 and LRCK = clk/256 (Fs = 46.875 kHz), accepts stereo samples over a valid/ready handshake into a one-deep holding register, and serialises them MSB-first in standard I2S format. Sits on the playback side of the audio path, mirroring the capture-side I2S receiver: same clock ratios and slot layout, opposite data direction.

## Interface
- WIDTH, 24, sample width per channel (1..31)
- CNT_W, 16, underrun counter width
- clk  in  1  system clock, 12 MHz; also forwarded as DAC system clock
- reset  in  1  synchronous, active-high
- en  in  1  transmitter enable; 0 = clocks parked, no loads
- mute  in  1  sampled at frame load; 1 = transmit zeros
- left_in  in  WIDTH  left sample, two's complement
- right_in  in  WIDTH  right sample, two's complement
- sample_valid  in  1  producer has a stereo pair on left_in/right_in
- sample_ready  out  1  holding register can accept a pair
- sample_req  out  1  one-cycle pulse at each frame load
- scki  out  1  = clk
- bck  out  1  bit clock, clk/4
- lrck  out  1  word clock, clk/256; 0 = left, 1 = right
- dout  out  1  serial data to DAC
- underrun  out  1  sticky: a frame load found the holding register empty
- underrun_cnt  out  CNT_W  saturating count of underrun events

## Operation
- 8-bit prescaler p increments every clk while en=1; held at 0 while en=0. bck = p[1], lrck = p[7], slot = p[6:2] (0..31 per half-frame).
- Slot map per half-frame: slot 0 = 0 (I2S one-bit delay); slots 1..WIDTH = sample bits WIDTH-1 down to 0; remaining slots = 0.
- dout is a register, updated on the clk edge where p[1:0] becomes 00 (coincident with bck falling), so it is stable across every bck rising edge. Value during slot k of channel c = bit defined above from active register c.
- Holding register (hold_l, hold_r, hold_full): written when sample_valid & sample_ready; sample_ready = ~hold_full (0 while reset asserted).
- Frame load event FL: en=1 and p == 8'hFF. On FL:
  - sample_req pulses for that cycle.
  - hold_full=1: active <= mute ? 0 : hold; hold_full <= 0.
  - hold_full=0: active <= 0; underrun <= 1; underrun_cnt += 1, saturating at all-ones.
- Simultaneous handshake and FL with hold empty: pair is written into hold (not active), FL still counts as underrun; pair transmits at the following FL.
- FL with hold full: ready is 0 that cycle; ready returns 1 the next cycle.
- en falling: p, bck, lrck, dout forced to 0 the next cycle; active, hold, counters retained. en rising: p restarts at 0, so the first half-frame is left and no FL occurs until p reaches 8'hFF.
- underrun and underrun_cnt cleared only by reset.

## Timing
- Reset values: p=0, bck=0, lrck=0, dout=0, sample_ready=0 during reset then 1, sample_req=0, active=0, hold_full=0, underrun=0, underrun_cnt=0.
- Reset mid-frame: all of the above on the next edge; a pending hold pair is discarded.
- First frame after reset transmits zeros with no underrun; first FL is 255 cycles after reset deasserts (p=8'hFF).
- Left MSB drives dout during p=4..7 of the frame following FL; right MSB during p=132..135; LSB (WIDTH=24) left during p=96..99.
- Latency accept->MSB on dout: 5 cycles minimum (accept at FL-1), 260 maximum.
- One pair consumed per 256 clk; producer must accept at most one pair per sample_req.

## Test plan
- Reset, then valid with left=0xA5A5A5, right=0x5A5A5A at cycle 10 -> ready drops, FL at cycle 255 clears hold, dout shifts 101001011010... left from p=4, right 0x5A5A5A from p=132, zeros in slot 0 and slots 25..31; underrun stays 0.
- No valid for 3 frames after reset -> underrun=1 at first FL, underrun_cnt=3 after third FL, dout all 0.
- Two valids back-to-back (0x111111, 0x222222) -> second stalls with ready=0 until cycle after FL, then transmits one frame after the first.
- mute=1 at FL with hold full (0x7FFFFF) -> dout all 0 that frame, hold emptied, no underrun; mute=0 next FL resumes data.
- en=0 at p=60 -> bck/lrck/dout 0 next cycle, no sample_req; en=1 -> p restarts at 0, next FL 255 cycles later, held pair intact.
- Force underrun_cnt to all-ones via CNT_W=2 build and 5 starved frames -> counter saturates at 3, underrun stays 1; reset mid-frame clears both and dout=0 next cycle.
